// File: rtl/vga_mode_select.sv
// ---------------------------------------------------------------------------
// vga_mode_select
//
// Front-end control for the colour-bar VGA generator. Two raw push-buttons
// are synchronised, debounced and turned into press events. The events step
// a 2-bit requested pattern. That request becomes the visible `mode` only at
// the falling edge of vsync, so a pattern change never lands mid-frame.
//
// Ports (vga_mode_select)
//   clk           system clock, shared with the VGA generator
//   reset         synchronous, active-high reset
//   btn_next      raw async button; a press advances the pattern
//   btn_prev      raw async button; a press steps the pattern back
//   vsync         generator vsync (low during sync lines), treated as async
//   mode[1:0]     committed pattern select -> generator key[1:0]
//   mode_pending  high while the requested pattern differs from `mode`
//   mode_changed  one-clock pulse after `mode` takes a new, different value
//
// Ports (vga_mode_select_debounce, one per button)
//   clk, reset    as above
//   btn_raw_i     raw asynchronous button level
//   press_o       combinational; high on the edge where the debounced level
//                 flips from released to pressed
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module vga_mode_select_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic press_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Level a button reads while nobody is touching it.
  localparam logic            RELEASED = (KEY_ACTIVE_LOW != 0);

  logic [1:0]       sync_q;
  logic             stb_q,  stb_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    stb_d   = stb_q;
    cnt_d   = cnt_q;
    press_o = 1'b0;
    if (sync_q[1] == stb_q) begin
      // Any bounce back to the stable level restarts the count.
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stb_d   = sync_q[1];
      cnt_d   = '0;
      // Only the released-to-pressed flip is an event.
      press_o = (sync_q[1] != RELEASED);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchroniser loads the released level so leaving reset with the
      // button up cannot look like a press.
      sync_q <= {2{RELEASED}};
      stb_q  <= RELEASED;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_raw_i};
      stb_q  <= stb_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

module vga_mode_select #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       vsync,
  output logic [1:0] mode,
  output logic       mode_pending,
  output logic       mode_changed
);

  logic       next_evt;
  logic       prev_evt;
  logic [1:0] vs_sync_q;   // [1] is the second sync stage (vs_s)
  logic       vs_d_q;      // one-clock-late copy of vs_s
  logic       vs_fall;
  logic [1:0] req_q,     req_d;
  logic [1:0] mode_q,    mode_d;
  logic       changed_q, changed_d;

  vga_mode_select_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
  ) u_db_next (
    .clk       (clk),
    .reset     (reset),
    .btn_raw_i (btn_next),
    .press_o   (next_evt)
  );

  vga_mode_select_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
  ) u_db_prev (
    .clk       (clk),
    .reset     (reset),
    .btn_raw_i (btn_prev),
    .press_o   (prev_evt)
  );

  assign vs_fall = vs_d_q & ~vs_sync_q[1];

  always_comb begin
    req_d     = req_q;
    mode_d    = mode_q;
    changed_d = 1'b0;

    // Simultaneous next and prev cancel out. 2-bit arithmetic gives the
    // modulo-4 wrap for free.
    unique case ({next_evt, prev_evt})
      2'b10:   req_d = req_q + 2'd1;
      2'b01:   req_d = req_q - 2'd1;
      default: req_d = req_q;
    endcase

    // Commit samples the pre-edge request: a request landing on the same
    // edge stays pending until the next frame.
    if (vs_fall) begin
      mode_d    = req_q;
      changed_d = (req_q != mode_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_sync_q <= 2'b11;
      vs_d_q    <= 1'b1;
      req_q     <= '0;
      mode_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      vs_sync_q <= {vs_sync_q[0], vsync};
      vs_d_q    <= vs_sync_q[1];
      req_q     <= req_d;
      mode_q    <= mode_d;
      changed_q <= changed_d;
    end
  end

  assign mode         = mode_q;
  assign mode_changed = changed_q;
  assign mode_pending = (req_q != mode_q);

endmodule

// File: tb/tb_vga_mode_select.sv
// ---------------------------------------------------------------------------
// tb_vga_mode_select
//
// Self-checking bench for vga_mode_select with DEBOUNCE_CYCLES=8 and
// active-low buttons. Directed sequences cover reset, latency, bounce,
// wrap-around, coincidences and mid-operation reset; a randomized phase then
// drives button gestures and frame commits against an arithmetic model that
// only counts accepted presses (req) and copies req into mode at each commit.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vga_mode_select;

  localparam int D = 8;

  logic       clk;
  logic       reset;
  logic       btn_next;
  logic       btn_prev;
  logic       vsync;
  logic [1:0] mode;
  logic       mode_pending;
  logic       mode_changed;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: pattern counters only.
  int req_m  = 0;
  int mode_m = 0;

  vga_mode_select #(
    .DEBOUNCE_CYCLES (D),
    .KEY_ACTIVE_LOW  (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_next     (btn_next),
    .btn_prev     (btn_prev),
    .vsync        (vsync),
    .mode         (mode),
    .mode_pending (mode_pending),
    .mode_changed (mode_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges; return 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input bit which_prev, input logic lvl);
    if (which_prev) btn_prev = lvl;
    else            btn_next = lvl;
  endtask

  task automatic bump(input bit which_prev);
    req_m = which_prev ? (req_m + 3) % 4 : (req_m + 1) % 4;
  endtask

  task automatic do_reset();
    btn_next = 1'b1;
    btn_prev = 1'b1;
    vsync    = 1'b1;
    reset    = 1'b1;
    tick(3);
    reset    = 1'b0;
    req_m    = 0;
    mode_m   = 0;
  endtask

  task automatic clean_press(input bit which_prev);
    set_btn(which_prev, 1'b0);
    tick(D + 4);
    set_btn(which_prev, 1'b1);
    tick(D + 4);
    bump(which_prev);
  endtask

  // Pulse vsync low for 4 clocks; expect mode <= req and one change pulse
  // exactly when the committed value differs.
  task automatic commit(input string tag);
    int pulses;
    int old_mode;
    pulses   = 0;
    old_mode = mode_m;
    vsync    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      pulses += 32'(mode_changed);
    end
    vsync = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      pulses += 32'(mode_changed);
    end
    mode_m = req_m;
    check({tag, "_mode"}, 32'(mode), mode_m);
    check({tag, "_pend"}, 32'(mode_pending), 0);
    check({tag, "_chg"},  pulses, (mode_m != old_mode) ? 1 : 0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_mode"}, 32'(mode), mode_m);
    check({tag, "_pend"}, 32'(mode_pending), (req_m != mode_m) ? 1 : 0);
  endtask

  initial begin
    int rise;
    int pulses;
    btn_next = 1'b1;
    btn_prev = 1'b1;
    vsync    = 1'b1;
    reset    = 1'b1;

    // 1. Reset state and idle stability.
    do_reset();
    check("t1_mode",    32'(mode),         0);
    check("t1_pend",    32'(mode_pending), 0);
    check("t1_chg",     32'(mode_changed), 0);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      pulses += 32'(mode_changed) + 32'(mode_pending) + 32'(mode);
    end
    check("t1_idle_activity", pulses, 0);

    // 2. Press latency and vsync-to-mode latency.
    rise     = -1;
    btn_next = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (rise < 0 && mode_pending) rise = i;
    end
    check("t2_pend_latency_10_11", (rise >= 10 && rise <= 11) ? rise : -rise, rise);
    if (!(rise >= 10 && rise <= 11))
      $display("FAIL t2_pend_window: got %0d expected 10..11", rise);
    req_m  = 1;
    pulses = 0;
    vsync  = 1'b0;
    tick(2);
    check("t2_mode_before_3rd_edge", 32'(mode), 0);
    tick(1);
    check("t2_mode_at_3rd_edge", 32'(mode), 1);
    pulses += 32'(mode_changed);
    tick(1);
    pulses += 32'(mode_changed);
    vsync = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      pulses += 32'(mode_changed);
    end
    mode_m = 1;
    check("t2_chg_pulses", pulses, 1);
    check("t2_pend_after", 32'(mode_pending), 0);
    btn_next = 1'b1;
    tick(D + 4);
    check_state("t2_release");

    // 3. Bounce shorter than the debounce window, then one clean hold.
    do_reset();
    for (int s = 0; s < 10; s++) begin
      btn_next = (s % 2 == 0) ? 1'b0 : 1'b1;
      tick(3);
    end
    check("t3_bounce_no_event", 32'(mode_pending), 0);
    btn_next = 1'b0;
    tick(12);
    btn_next = 1'b1;
    tick(D + 4);
    req_m = 1;
    check("t3_pend", 32'(mode_pending), 1);
    commit("t3");

    // 4. Backwards wrap, then four presses in one frame returning to 3.
    do_reset();
    clean_press(1'b1);
    commit("t4a");
    check("t4a_wrap3", 32'(mode), 3);
    for (int i = 0; i < 4; i++) clean_press(1'b0);
    check("t4_pend_after_4", 32'(mode_pending), 0);
    commit("t4b");

    // 5a. Both flips on the same edge cancel.
    do_reset();
    btn_next = 1'b0;
    btn_prev = 1'b0;
    tick(D + 4);
    check("t5_both_pend", 32'(mode_pending), 0);
    btn_next = 1'b1;
    btn_prev = 1'b1;
    tick(D + 4);
    commit("t5a");

    // 5b. Next flip (edge 10 after press) coincides with the commit edge
    // (3rd edge after a vsync fall first seen on edge 8).
    btn_next = 1'b0;
    tick(7);
    vsync = 1'b0;
    tick(3);
    req_m = 1;
    check("t5b_mode_old", 32'(mode), 0);
    check("t5b_pend",     32'(mode_pending), 1);
    tick(1);
    vsync = 1'b1;
    btn_next = 1'b1;
    tick(D + 4);
    check("t5b_still_old", 32'(mode), 0);
    commit("t5b");

    // 6. Reset during a partially debounced press.
    do_reset();
    btn_next = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(2);
    check("t6_in_reset_pend", 32'(mode_pending), 0);
    reset = 1'b0;
    tick(9);
    check("t6_no_early_event", 32'(mode_pending), 0);
    tick(1);
    check("t6_event", 32'(mode_pending), 1);
    check("t6_mode_held", 32'(mode), 0);
    req_m = 1;
    btn_next = 1'b1;
    tick(D + 4);
    commit("t6");

    // Randomized gestures against the counting model.
    do_reset();
    for (int it = 0; it < 40; it++) begin
      int act;
      int k;
      bit which;
      act   = $urandom_range(0, 5);
      which = 1'($urandom_range(0, 1));
      k     = $urandom_range(1, D - 2);
      case (act)
        0, 1: clean_press(which);
        2: begin
          // Glitch press shorter than the debounce window.
          set_btn(which, 1'b0);
          tick(k);
          set_btn(which, 1'b1);
          tick(D + 4);
        end
        3: commit("rnd_commit");
        4: begin
          btn_next = 1'b0;
          btn_prev = 1'b0;
          tick(D + 4);
          btn_next = 1'b1;
          btn_prev = 1'b1;
          tick(D + 4);
        end
        default: begin
          // Long hold with a short release glitch: still one event.
          set_btn(which, 1'b0);
          tick(D + 4);
          set_btn(which, 1'b1);
          tick(k);
          set_btn(which, 1'b0);
          tick(D + 4);
          set_btn(which, 1'b1);
          tick(D + 4);
          bump(which);
        end
      endcase
      if (act != 3) check_state("rnd_state");
    end
    commit("rnd_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
